// File: rtl/mac_lookup_learn_pkg.sv
// rtl/mac_lookup_learn_pkg.sv - shared field offsets, FSM codes and sizing helpers
package mac_lookup_learn_pkg;

  localparam int SRC_PORT_POS = 16;
  localparam int DST_PORT_POS = 24;
  localparam int MAC_W        = 48;
  localparam int DST_MAC_POS  = 0;
  localparam int SRC_MAC_POS  = 48;

  localparam logic [0:0] HEADER = 1'b0;
  localparam logic [0:0] BODY   = 1'b1;

  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // {valid, mac, port}
  function automatic int entry_width(input int num_ports);
    return 1 + MAC_W + num_ports;
  endfunction

endpackage

// File: rtl/mac_lookup_learn_mac_table.sv
// rtl/mac_lookup_learn_mac_table.sv - fully-associative MAC table with FIFO replacement
module mac_table
  import mac_lookup_learn_pkg::*;
#(
  parameter int NUM_PORTS   = 7,
  parameter int NUM_ENTRIES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [MAC_W-1:0]     lookup_mac_i,
  output logic                 hit_o,
  output logic [NUM_PORTS-1:0] hit_port_o,
  input  logic                 learn_en_i,
  input  logic [MAC_W-1:0]     learn_mac_i,
  input  logic [NUM_PORTS-1:0] learn_port_i
);

  localparam int EW    = entry_width(NUM_PORTS);
  localparam int IDX_W = log2(NUM_ENTRIES);

  logic [EW-1:0]    entry_q [NUM_ENTRIES];
  logic [IDX_W-1:0] replace_ptr_q, replace_ptr_d;
  logic             learn_hit;
  logic [IDX_W-1:0] learn_idx;

  // Lookup and learn match run against the pre-write table, so a same-cycle learn is invisible to lookup.
  always_comb begin
    hit_o      = 1'b0;
    hit_port_o = '0;
    learn_hit  = 1'b0;
    learn_idx  = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (entry_q[i][EW-1] && (entry_q[i][NUM_PORTS +: MAC_W] == lookup_mac_i)) begin
        hit_o      = 1'b1;
        hit_port_o = hit_port_o | entry_q[i][NUM_PORTS-1:0];
      end
      if (entry_q[i][EW-1] && (entry_q[i][NUM_PORTS +: MAC_W] == learn_mac_i)) begin
        learn_hit = 1'b1;
        learn_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    replace_ptr_d = replace_ptr_q;
    if (learn_en_i && !learn_hit) replace_ptr_d = replace_ptr_q + IDX_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      replace_ptr_q <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) entry_q[i] <= '0;
    end else begin
      replace_ptr_q <= replace_ptr_d;
      if (learn_en_i) begin
        if (learn_hit) entry_q[learn_idx][NUM_PORTS-1:0] <= learn_port_i;
        else           entry_q[replace_ptr_q] <= {1'b1, learn_mac_i, learn_port_i};
      end
    end
  end

endmodule

// File: rtl/mac_lookup_learn.sv
// rtl/mac_lookup_learn.sv - header lookup/learn stage writing the destination port vector into tuser
module mac_lookup_learn
  import mac_lookup_learn_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_PORTS            = 7,
  parameter int NUM_ENTRIES          = 16
) (
  input  logic                                 axis_aclk,
  input  logic                                 axis_resetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
  input  logic                                 s_axis_tvalid,
  input  logic                                 s_axis_tlast,
  output logic                                 s_axis_tready,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
  output logic                                 m_axis_tvalid,
  output logic                                 m_axis_tlast,
  input  logic                                 m_axis_tready,
  output logic                                 lut_hit,
  output logic                                 lut_miss
);

  logic [C_M_AXIS_DATA_WIDTH-1:0]   tdata_q;
  logic [C_M_AXIS_DATA_WIDTH/8-1:0] tkeep_q;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]  tuser_q, tuser_d;
  logic                             tvalid_q, tvalid_d, tlast_q;
  logic                             hit_q, miss_q, hit_d, miss_d;
  logic [0:0]                       in_pkt_q, in_pkt_d;

  logic                 accept, is_hdr;
  logic [MAC_W-1:0]     dst_mac, src_mac;
  logic [NUM_PORTS-1:0] src_port, flood, dst_vec, tbl_port;
  logic                 tbl_hit;

  assign s_axis_tready = !tvalid_q || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign is_hdr        = (in_pkt_q == HEADER);
  assign dst_mac       = s_axis_tdata[DST_MAC_POS +: MAC_W];
  assign src_mac       = s_axis_tdata[SRC_MAC_POS +: MAC_W];
  assign src_port      = s_axis_tuser[SRC_PORT_POS +: NUM_PORTS];
  assign flood         = ~src_port;

  mac_table #(
    .NUM_PORTS   (NUM_PORTS),
    .NUM_ENTRIES (NUM_ENTRIES)
  ) u_mac_table (
    .clk          (axis_aclk),
    .rst_n        (axis_resetn),
    .lookup_mac_i (dst_mac),
    .hit_o        (tbl_hit),
    .hit_port_o   (tbl_port),
    .learn_en_i   (accept && is_hdr && !src_mac[0]),
    .learn_mac_i  (src_mac),
    .learn_port_i (src_port)
  );

  // A hit back onto the ingress port is filtered (empty vector) but still reported as a miss.
  always_comb begin
    dst_vec = flood;
    hit_d   = 1'b0;
    miss_d  = 1'b1;
    if (!dst_mac[0] && tbl_hit) begin
      if (tbl_port == src_port) begin
        dst_vec = '0;
      end else begin
        dst_vec = tbl_port;
        hit_d   = 1'b1;
        miss_d  = 1'b0;
      end
    end
  end

  always_comb begin
    tuser_d = s_axis_tuser;
    if (is_hdr) tuser_d[DST_PORT_POS +: NUM_PORTS] = dst_vec;
    in_pkt_d = in_pkt_q;
    if (accept) in_pkt_d = s_axis_tlast ? HEADER : BODY;
    tvalid_d = accept ? 1'b1 : (m_axis_tready ? 1'b0 : tvalid_q);
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      in_pkt_q <= HEADER;
      tvalid_q <= 1'b0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tuser_q  <= '0;
      tlast_q  <= 1'b0;
    end else begin
      in_pkt_q <= in_pkt_d;
      tvalid_q <= tvalid_d;
      hit_q    <= accept && is_hdr && hit_d;
      miss_q   <= accept && is_hdr && miss_d;
      if (accept) begin
        tdata_q <= s_axis_tdata;
        tkeep_q <= s_axis_tkeep;
        tuser_q <= tuser_d;
        tlast_q <= s_axis_tlast;
      end
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign lut_hit       = hit_q;
  assign lut_miss      = miss_q;

endmodule

// File: tb/tb_mac_lookup_learn.sv
// tb/tb_mac_lookup_learn.sv - scoreboard bench with a behavioural MAC-learning model
module tb_mac_lookup_learn;

  localparam int DW = 256;
  localparam int KW = 32;
  localparam int UW = 128;
  localparam int NP = 7;
  localparam int NE = 16;

  logic          axis_aclk = 1'b0;
  logic          axis_resetn = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '0;
  logic [UW-1:0] s_axis_tuser = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b1;
  logic          lut_hit, lut_miss;

  always #5 axis_aclk = ~axis_aclk;

  mac_lookup_learn #(
    .C_M_AXIS_DATA_WIDTH(DW), .C_S_AXIS_DATA_WIDTH(DW),
    .C_M_AXIS_TUSER_WIDTH(UW), .C_S_AXIS_TUSER_WIDTH(UW),
    .NUM_PORTS(NP), .NUM_ENTRIES(NE)
  ) dut (
    .axis_aclk(axis_aclk), .axis_resetn(axis_resetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .lut_hit(lut_hit), .lut_miss(lut_miss)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  beat_t      exp_q[$];
  logic [1:0] pulse_q[$];
  beat_t      mon_e;
  logic [1:0] mon_p;
  int         pass_cnt = 0;
  int         chk_cnt = 0;
  int         rdy_mode = 0;
  bit         mon_en = 0;

  // reference table: MAC -> port binding with insertion-order replacement
  bit         tv[NE];
  logic [47:0] tm[NE];
  logic [6:0]  tp[NE];
  int          ptr;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NE; i++) tv[i] = 0;
    ptr = 0;
  endtask

  task automatic model_header(input logic [47:0] dst, input logic [47:0] src, input logic [6:0] sport,
                              output logic [6:0] dvec, output bit hit);
    int f;
    f = -1;
    for (int i = 0; i < NE; i++) if (tv[i] && tm[i] == dst) f = i;
    hit  = 0;
    dvec = ~sport;
    if (!dst[0] && f >= 0) begin
      if (tp[f] == sport) dvec = 7'h00;
      else begin dvec = tp[f]; hit = 1; end
    end
    if (!src[0]) begin
      f = -1;
      for (int i = 0; i < NE; i++) if (tv[i] && tm[i] == src) f = i;
      if (f >= 0) tp[f] = sport;
      else begin
        tv[ptr] = 1; tm[ptr] = src; tp[ptr] = sport;
        ptr = (ptr + 1) % NE;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge axis_aclk);
      #1;
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ($urandom_range(0, 3) != 0);
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  always @(negedge axis_aclk) begin
    if (mon_en) begin
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL out_beat: got unexpected beat tdata %0h, expected none", m_axis_tdata);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_tdata", m_axis_tdata, mon_e.d);
          check("out_tuser", m_axis_tuser, mon_e.u);
          check("out_tkeep_tlast", {m_axis_tkeep, m_axis_tlast}, {mon_e.k, mon_e.l});
        end
      end
      if (lut_hit || lut_miss) begin
        if (pulse_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL lut_pulse: got hit=%0d miss=%0d, expected no pulse", lut_hit, lut_miss);
        end else begin
          mon_p = pulse_q.pop_front();
          check("lut_hit_miss", {lut_hit, lut_miss}, mon_p);
        end
      end
    end
  end

  task automatic drive_beat(input beat_t in_b, input beat_t ex_b, input bit hdr, input logic [1:0] pulse);
    int n;
    s_axis_tdata  = in_b.d;
    s_axis_tkeep  = in_b.k;
    s_axis_tuser  = in_b.u;
    s_axis_tlast  = in_b.l;
    s_axis_tvalid = 1'b1;
    n = 0;
    forever begin
      @(negedge axis_aclk);
      if (s_axis_tready) break;
      n++;
      if (n > 200) break;
    end
    if (n > 200) begin
      chk_cnt++;
      $display("FAIL accept_timeout: got tready=0 for 200 cycles, expected acceptance");
    end else begin
      exp_q.push_back(ex_b);
      if (hdr) pulse_q.push_back(pulse);
    end
    @(posedge axis_aclk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input logic [47:0] dst, input logic [47:0] src, input int port, input int nbeats,
                          input bit use_exp, input logic [6:0] xdst, input bit xhit);
    beat_t      ib, eb;
    logic [6:0] mdst, sport;
    bit         mhit;
    sport = 7'(1 << port);
    for (int b = 0; b < nbeats; b++) begin
      for (int w = 0; w < 8; w++) ib.d[w*32 +: 32] = $urandom();
      for (int w = 0; w < 4; w++) ib.u[w*32 +: 32] = $urandom();
      ib.u[16 +: 7] = sport;
      ib.l = (b == nbeats - 1);
      ib.k = ib.l ? KW'($urandom()) : '1;
      eb = ib;
      mhit = 0;
      if (b == 0) begin
        ib.d[47:0]  = dst;
        ib.d[95:48] = src;
        eb.d = ib.d;
        model_header(dst, src, sport, mdst, mhit);
        if (use_exp) begin mdst = xdst; mhit = xhit; end
        eb.u[24 +: 7] = mdst;
      end
      drive_beat(ib, eb, (b == 0), {mhit, !mhit});
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || pulse_q.size() != 0) && n < 1000) begin
      @(negedge axis_aclk);
      n++;
    end
    if (n >= 1000) begin
      chk_cnt++;
      $display("FAIL drain: got %0d beats outstanding, expected 0", exp_q.size());
    end
    @(posedge axis_aclk);
    #1;
  endtask

  task automatic do_reset();
    mon_en = 0;
    rdy_mode = 0;
    s_axis_tvalid = 1'b0;
    axis_resetn = 1'b0;
    repeat (3) @(posedge axis_aclk);
    exp_q.delete();
    pulse_q.delete();
    model_reset();
    @(negedge axis_aclk);
    check("reset_m_tvalid", m_axis_tvalid, 0);
    check("reset_lut_pulses", {lut_hit, lut_miss}, 0);
    @(posedge axis_aclk);
    #1;
    axis_resetn = 1'b1;
    mon_en = 1;
    check("reset_s_tready", s_axis_tready, 1);
  endtask

  localparam logic [47:0] MAC_A  = 48'h0000_0000_0A02;
  localparam logic [47:0] MAC_B  = 48'h0000_0000_0B04;
  localparam logic [47:0] MAC_AM = 48'h0000_0000_0A01;
  localparam logic [47:0] BCAST  = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SRC_MC = 48'h0000_0000_7701;

  logic [47:0] pool[20];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    send_pkt(MAC_B, MAC_A, 0, 1, 1, 7'h7E, 0);
    send_pkt(MAC_A, MAC_B, 2, 1, 1, 7'h01, 1);
    check("latency_tvalid", m_axis_tvalid, 1);
    check("latency_lut_hit", lut_hit, 1);
    send_pkt(BCAST, 48'h0000_0000_0C06, 3, 5, 1, 7'h77, 0);
    send_pkt(MAC_B, MAC_AM, 1, 2, 1, 7'h04, 1);
    send_pkt(MAC_AM, 48'h0000_0000_0D08, 5, 1, 1, 7'h5F, 0);
    drain();

    // fill beyond capacity so the oldest binding is replaced on wrap
    do_reset();
    for (int i = 0; i < 17; i++)
      send_pkt(BCAST, 48'h0000_1000_0000 + 48'(i << 1), i % 7, 1, 1, ~7'(1 << (i % 7)), 0);
    send_pkt(48'h0000_1000_0000, SRC_MC, 6, 1, 1, 7'h3F, 0);
    send_pkt(48'h0000_1000_0020, SRC_MC, 6, 1, 1, 7'h04, 1);
    drain();

    // output stall mid-packet
    rdy_mode = 2;
    m_axis_tready = 1'b0;
    fork
      send_pkt(48'h0000_1000_0020, SRC_MC, 0, 4, 1, 7'h04, 1);
    join_none
    @(posedge axis_aclk);
    repeat (5) begin
      @(negedge axis_aclk);
      check("stall_s_tready", s_axis_tready, 0);
    end
    rdy_mode = 1;
    wait fork;
    drain();
    rdy_mode = 0;
    send_pkt(48'h0000_1000_0020, SRC_MC, 1, 1, 1, 7'h04, 1);
    drain();

    // station move updates in place without advancing the replacement pointer
    do_reset();
    send_pkt(BCAST, MAC_A, 0, 1, 1, 7'h7E, 0);
    send_pkt(BCAST, MAC_A, 4, 1, 1, 7'h6F, 0);
    for (int i = 0; i < 15; i++)
      send_pkt(BCAST, 48'h0000_2000_0000 + 48'(i << 1), 1, 1, 1, 7'h7D, 0);
    send_pkt(MAC_A, SRC_MC, 4, 1, 1, 7'h00, 0);
    send_pkt(MAC_A, SRC_MC, 1, 1, 1, 7'h10, 1);
    drain();

    for (int i = 0; i < 20; i++) pool[i] = {16'h0002, 32'($urandom())} & ~48'h1;
    rdy_mode = 1;
    for (int p = 0; p < 150; p++) begin
      logic [47:0] d, s;
      s = pool[$urandom_range(0, 19)];
      if ($urandom_range(0, 9) == 0) s = s | 48'h1;
      d = ($urandom_range(0, 9) == 0) ? BCAST : pool[$urandom_range(0, 19)];
      send_pkt(d, s, $urandom_range(0, 6), $urandom_range(1, 5), 0, 7'h00, 0);
    end
    drain();
    rdy_mode = 0;

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
